sram22_port_ctrl: RTL and testbench
===================================

// Module: sram22_port_ctrl
// PURPOSE
//   Initiator-side controller for one sram22 single-port macro (e.g. 2048x8, mask width 8).
//   - Accepts read/write requests on a valid/ready channel and drives the macro's ce/we/wmask/addr/din pins.
//   - Captures dout one cycle after each read and returns it in order on a valid/ready response channel.
//   - Optionally zero-fills the array after reset before accepting traffic.
// PARAMETERS
//   ADDR_WIDTH      11  address bits; depth = 1<<ADDR_WIDTH
//   DATA_WIDTH      8   word width
//   WMASK_WIDTH     8   mask bits; each covers DATA_WIDTH/WMASK_WIDTH bits (must divide evenly)
//   CLEAR_ON_RESET  1   1: zero-fill the whole array after reset; 0: go straight to RUN
// PORTS
//   clk        in   1            clock; all logic on posedge
//   rst        in   1            synchronous reset, active-high
//   req_valid  in   1            request present
//   req_ready  out  1            request accepted when valid&ready
//   req_we     in   1            1 = write, 0 = read
//   req_addr   in   ADDR_WIDTH   word address
//   req_wmask  in   WMASK_WIDTH  write mask; ignored for reads
//   req_din    in   DATA_WIDTH   write data
//   rsp_valid  out  1            read data available
//   rsp_ready  in   1            consumer takes data when valid&ready
//   rsp_dout   out  DATA_WIDTH   read data, in request order
//   init_done  out  1            1 once in RUN state
//   sram_rstb  out  1            macro reset bar = ~rst (combinational)
//   sram_ce    out  1            macro chip enable
//   sram_we    out  1            macro write enable
//   sram_wmask out  WMASK_WIDTH  macro write mask
//   sram_addr  out  ADDR_WIDTH   macro address
//   sram_din   out  DATA_WIDTH   macro write data
//   sram_dout  in   DATA_WIDTH   macro read data; valid the cycle after a read, held until the next read
// BEHAVIOUR
//   Reset values:
//     req_ready=0, rsp_valid=0, rsp_dout=0, init_done=0, sram_ce=0.
//     Response FIFO empty, in-flight flag clear, clear counter 0.
//     State = CLEAR if CLEAR_ON_RESET else RUN.
//   FSM CLEAR:
//     - Each cycle: sram_ce=1, sram_we=1, sram_wmask=all ones, sram_din=0, sram_addr=clear counter; counter +1.
//     - After writing address DEPTH-1 -> RUN. Takes exactly DEPTH cycles; req_ready=0 throughout.
//   FSM RUN:
//     - init_done=1. No further state transitions except via rst.
//     - Macro pins are combinational from the request: sram_ce = req_valid&req_ready; we/wmask/addr/din = req_*.
//     - Pins are 0 when idle; sram_we=0 whenever sram_ce=0.
//   Read latency:
//     - Read accepted in cycle N; sram_dout sampled in cycle N+1 and pushed to a 2-entry response FIFO.
//     - rsp_valid is asserted at earliest in cycle N+1, combinationally from FIFO head via bypass.
//     - Sustained 1 read/cycle when rsp_ready=1.
//   Credit / backpressure:
//     - occ = FIFO entries + in-flight read (0..2).
//     - req_ready = RUN && (req_we || occ - pop_this_cycle < 2), where pop = rsp_valid&rsp_ready.
//     - Writes are never blocked by response backpressure. No read data is ever dropped or duplicated.
//   Write semantics:
//     - Masked bits are written at the acceptance edge; no response is generated.
//     - A read accepted the cycle after a write to the same address returns the new data.
//   Ordering: one request per cycle, strictly in order; responses in read-acceptance order.
//   Reset mid-operation:
//     - FIFO and in-flight read are discarded; rsp_valid drops the cycle after rst.
//     - CLEAR restarts from address 0.
//     - sram_rstb=0 while rst=1.
//   Widths: clear counter has ADDR_WIDTH+1 bits; terminal count detected without wrap.
// TESTING
//   1. CLEAR_ON_RESET=1, release rst at cycle 0 -> sram_ce=1/we=1 for 2048 cycles on addr 0..2047;
//      init_done=1 and req_ready=1 at cycle 2048; reading addr 5 returns 8'h00.
//   2. Write addr 0x10=8'hA5 with wmask 8'hFF, then write 8'h0F with wmask 8'h0F, then read 0x10
//      -> rsp_dout=8'hAF, rsp_valid one cycle after read acceptance.
//   3. Back-to-back reads of addr 1,2,3 (preloaded 8'h11/8'h22/8'h33), rsp_ready=1
//      -> rsp_valid for 3 consecutive cycles with 11,22,33; req_ready never drops.
//   4. rsp_ready=0, issue 4 reads -> only 2 accepted (req_ready=0 after); interleaved write accepted;
//      raise rsp_ready -> 2 responses in order, then remaining reads proceed.
//   5. Write 8'h3C to addr 7, then read addr 7 the next cycle -> rsp_dout=8'h3C.
//   6. Assert rst with 2 responses pending in CLEAR_ON_RESET=0 mode -> rsp_valid=0 next cycle,
//      sram_rstb=0 during rst, req_ready=1 the first cycle after rst falls; no stale response emitted.

Source files
------------

// File: rtl/sram22_port_ctrl_if.sv
// Request/response handshake bundle between a client (master) and the
// sram22 port controller (slave).
interface sram22_port_ctrl_if #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 8,
  parameter int WMASK_WIDTH = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [WMASK_WIDTH-1:0] req_wmask;
  logic [DATA_WIDTH-1:0]  req_din;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_WIDTH-1:0]  rsp_dout;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_din, rsp_ready,
    input  req_ready, rsp_valid, rsp_dout
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_din, rsp_ready,
    output req_ready, rsp_valid, rsp_dout
  );
endinterface

// File: rtl/sram22_port_ctrl.sv
// Initiator-side controller for one sram22 single-port macro: optional
// zero-fill after reset, then in-order reads/writes with credit-based read flow control.
module sram22_port_ctrl #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 8,
  parameter int WMASK_WIDTH    = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  sram22_port_ctrl_if.slave      bus,
  output logic                   init_done_o,
  output logic                   sram_rstb_o,
  output logic                   sram_ce_o,
  output logic                   sram_we_o,
  output logic [WMASK_WIDTH-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0]  sram_addr_o,
  output logic [DATA_WIDTH-1:0]  sram_din_o,
  input  logic [DATA_WIDTH-1:0]  sram_dout_i
);

  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [0:0] {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   clr_cnt_q;
  logic                  init_done_q;

  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  inflight_q;

  logic                  run;
  logic                  fifo_empty;
  logic                  pop;
  logic                  pop_fifo;
  logic                  push;
  logic [2:0]            occ;
  logic                  req_fire;
  logic                  rd_accept;

  assign sram_rstb_o = ~rst;
  assign init_done_o = init_done_q;
  assign run         = (state_q == ST_RUN) && !rst;

  // Response path: FIFO head when non-empty, otherwise bypass the macro output
  // during the cycle right after a read so data appears one cycle after acceptance.
  assign fifo_empty   = (count_q == 2'd0);
  assign bus.rsp_valid = !fifo_empty || inflight_q;
  assign bus.rsp_dout  = !fifo_empty ? fifo_q[rd_ptr_q]
                       : (inflight_q ? sram_dout_i : '0);
  assign pop      = bus.rsp_valid && bus.rsp_ready;
  assign pop_fifo = pop && !fifo_empty;
  assign push     = inflight_q && !(fifo_empty && pop);

  // Credits cover both stored responses and the read still inside the macro.
  assign occ           = {1'b0, count_q} + {2'b00, inflight_q};
  assign bus.req_ready = run && (bus.req_we || ((occ - {2'b00, pop}) < 3'd2));
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign rd_accept     = req_fire && !bus.req_we;

  assign count_d = count_q + {1'b0, push} - {1'b0, pop_fifo};

  always_comb begin
    sram_ce_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        sram_ce_o    = 1'b1;
        sram_we_o    = 1'b1;
        sram_wmask_o = '1;
        sram_addr_o  = clr_cnt_q[ADDR_WIDTH-1:0];
      end else if (req_fire) begin
        sram_ce_o    = 1'b1;
        sram_we_o    = bus.req_we;
        sram_wmask_o = bus.req_wmask;
        sram_addr_o  = bus.req_addr;
        sram_din_o   = bus.req_din;
      end
    end
  end

  // The extra counter bit lets the last address be compared without wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q   <= '0;
      init_done_q <= !CLEAR_ON_RESET;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      inflight_q <= rd_accept;
      count_q    <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= sram_dout_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_fifo) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_sram22_port_ctrl.sv
// Directed bench for sram22_port_ctrl: two instances (clear-on-reset and not),
// behavioural macro models, and a per-instance scoreboard of expected read data.
module tb_sram22_port_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int MW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst1, rst0;

  sram22_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) bus1 ();
  sram22_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) bus0 ();

  logic          initDone1, sramRstb1, sramCe1, sramWe1;
  logic [MW-1:0] sramWmask1;
  logic [AW-1:0] sramAddr1;
  logic [DW-1:0] sramDin1, sramDout1;

  logic          initDone0, sramRstb0, sramCe0, sramWe0;
  logic [MW-1:0] sramWmask0;
  logic [AW-1:0] sramAddr0;
  logic [DW-1:0] sramDin0, sramDout0;

  sram22_port_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .CLEAR_ON_RESET(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .init_done_o(initDone1),
    .sram_rstb_o(sramRstb1), .sram_ce_o(sramCe1), .sram_we_o(sramWe1),
    .sram_wmask_o(sramWmask1), .sram_addr_o(sramAddr1), .sram_din_o(sramDin1),
    .sram_dout_i(sramDout1)
  );

  sram22_port_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .CLEAR_ON_RESET(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0), .init_done_o(initDone0),
    .sram_rstb_o(sramRstb0), .sram_ce_o(sramCe0), .sram_we_o(sramWe0),
    .sram_wmask_o(sramWmask0), .sram_addr_o(sramAddr0), .sram_din_o(sramDin0),
    .sram_dout_i(sramDout0)
  );

  // Macro models: random power-up contents, dout held until the next read.
  logic [DW-1:0] sramMem1 [DEPTH];
  logic [DW-1:0] sramMem0 [DEPTH];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < DEPTH; i++) begin
        sramMem1[i] = 8'($urandom);
        sramMem0[i] = 8'($urandom);
      end
    end
    if (!sramRstb1) sramDout1 <= '0;
    else if (sramCe1 && !sramWe1) sramDout1 <= sramMem1[sramAddr1];
    if (sramCe1 && sramWe1)
      sramMem1[sramAddr1] = (sramMem1[sramAddr1] & ~sramWmask1) | (sramDin1 & sramWmask1);
    if (!sramRstb0) sramDout0 <= '0;
    else if (sramCe0 && !sramWe0) sramDout0 <= sramMem0[sramAddr0];
    if (sramCe0 && sramWe0)
      sramMem0[sramAddr0] = (sramMem0[sramAddr0] & ~sramWmask0) | (sramDin0 & sramWmask0);
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: reference contents updated on accepted writes, expected data
  // queued on accepted reads and compared when a response is handed over.
  logic [DW-1:0] refMem1 [DEPTH];
  logic [DW-1:0] refMem0 [DEPTH];
  logic [DW-1:0] expQ1 [$];
  logic [DW-1:0] expQ0 [$];
  int            rspCyc1 [$];
  int            stall1 = 0;

  always @(negedge clk) begin
    if (rst1) begin
      expQ1.delete();
      for (int i = 0; i < DEPTH; i++) refMem1[i] = '0;
    end else begin
      if (bus1.rsp_valid && bus1.rsp_ready) begin
        rspCyc1.push_back(cyc);
        checkOutput("rsp1_expected", 32'(expQ1.size() != 0), 32'd1);
        if (expQ1.size() != 0) checkOutput("rsp1_data", 32'(bus1.rsp_dout), 32'(expQ1.pop_front()));
      end
      if (bus1.req_valid && !bus1.req_ready) stall1++;
      if (bus1.req_valid && bus1.req_ready) begin
        if (bus1.req_we)
          refMem1[bus1.req_addr] = (refMem1[bus1.req_addr] & ~bus1.req_wmask) | (bus1.req_din & bus1.req_wmask);
        else
          expQ1.push_back(refMem1[bus1.req_addr]);
      end
    end
    if (rst0) begin
      expQ0.delete();
    end else begin
      if (bus0.rsp_valid && bus0.rsp_ready) begin
        checkOutput("rsp0_expected", 32'(expQ0.size() != 0), 32'd1);
        if (expQ0.size() != 0) checkOutput("rsp0_data", 32'(bus0.rsp_dout), 32'(expQ0.pop_front()));
      end
      if (bus0.req_valid && bus0.req_ready) begin
        if (bus0.req_we)
          refMem0[bus0.req_addr] = (refMem0[bus0.req_addr] & ~bus0.req_wmask) | (bus0.req_din & bus0.req_wmask);
        else
          expQ0.push_back(refMem0[bus0.req_addr]);
      end
    end
  end

  task automatic applyStimulus(input bit sel, input bit we, input logic [AW-1:0] addr,
                               input logic [MW-1:0] mask, input logic [DW-1:0] din);
    bit accepted = 1'b0;
    if (sel) begin
      bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_addr = addr;
      bus1.req_wmask = mask; bus1.req_din = din;
    end else begin
      bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_addr = addr;
      bus0.req_wmask = mask; bus0.req_din = din;
    end
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(negedge clk);
      accepted = sel ? bus1.req_ready : bus0.req_ready;
      @(posedge clk); #1;
    end
    checkOutput("req_accept_timeout", 32'(accepted), 32'd1);
    if (sel) bus1.req_valid = 1'b0;
    else     bus0.req_valid = 1'b0;
  endtask

  task automatic waitDrain(input bit sel);
    for (int n = 0; n < 64; n++) begin
      if ((sel ? expQ1.size() : expQ0.size()) == 0) break;
      @(posedge clk); #1;
    end
    checkOutput("drain_timeout", 32'(sel ? expQ1.size() : expQ0.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int clrBad;
    int staleCnt;
    rst1 = 1'b1; rst0 = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_wmask = '0;   bus1.req_din = '0;  bus1.rsp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
    bus0.req_wmask = '0;   bus0.req_din = '0;  bus0.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(bus1.req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    checkOutput("rst_rsp_dout", 32'(bus1.rsp_dout), 32'd0);
    checkOutput("rst_init_done", 32'(initDone1), 32'd0);
    checkOutput("rst_sram_ce", 32'(sramCe1), 32'd0);
    checkOutput("rst_sram_rstb", 32'(sramRstb1), 32'd0);

    // Test 1: zero-fill sweep over every address, then read back.
    @(posedge clk); #1;
    rst1 = 1'b0;
    clrBad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [AW-1:0] kAddr;
      kAddr = k[AW-1:0];
      @(negedge clk);
      if (!(sramCe1 === 1'b1 && sramWe1 === 1'b1 && sramAddr1 === kAddr &&
            sramWmask1 === 8'hFF && sramDin1 === 8'h00 &&
            bus1.req_ready === 1'b0 && initDone1 === 1'b0)) clrBad++;
    end
    checkOutput("clear_sweep_bad_cycles", 32'(clrBad), 32'd0);
    @(negedge clk);
    checkOutput("clear_done_init", 32'(initDone1), 32'd1);
    checkOutput("clear_done_ready", 32'(bus1.req_ready), 32'd1);
    checkOutput("clear_done_ce_idle", 32'(sramCe1), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 11'd5, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 11'd2047, 8'h00, 8'h00);
    waitDrain(1'b1);

    // Test 2: masked overwrite, response one cycle after read acceptance.
    applyStimulus(1'b1, 1'b1, 11'h010, 8'hFF, 8'hA5);
    applyStimulus(1'b1, 1'b1, 11'h010, 8'h0F, 8'h0F);
    applyStimulus(1'b1, 1'b0, 11'h010, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t2_rsp_valid_latency", 32'(bus1.rsp_valid), 32'd1);
    checkOutput("t2_rsp_dout", 32'(bus1.rsp_dout), 32'hAF);
    @(posedge clk); #1;
    waitDrain(1'b1);

    // Test 3: back-to-back reads at full rate.
    applyStimulus(1'b1, 1'b1, 11'd1, 8'hFF, 8'h11);
    applyStimulus(1'b1, 1'b1, 11'd2, 8'hFF, 8'h22);
    applyStimulus(1'b1, 1'b1, 11'd3, 8'hFF, 8'h33);
    rspCyc1.delete();
    stall1 = 0;
    applyStimulus(1'b1, 1'b0, 11'd1, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 11'd2, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 11'd3, 8'h00, 8'h00);
    waitDrain(1'b1);
    checkOutput("t3_stall_cycles", 32'(stall1), 32'd0);
    checkOutput("t3_rsp_count", 32'(rspCyc1.size()), 32'd3);
    if (rspCyc1.size() == 3)
      checkOutput("t3_rsp_consecutive", 32'(rspCyc1[2] - rspCyc1[0]), 32'd2);

    // Test 4: response backpressure limits reads to two; writes still pass.
    bus1.rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 11'd1, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 11'd2, 8'h00, 8'h00);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 11'd3;
    @(negedge clk);
    checkOutput("t4_ready_low_a", 32'(bus1.req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t4_ready_low_b", 32'(bus1.req_ready), 32'd0);
    checkOutput("t4_rsp_valid_held", 32'(bus1.rsp_valid), 32'd1);
    @(posedge clk); #1;
    bus1.req_we = 1'b1; bus1.req_addr = 11'h020; bus1.req_wmask = 8'hFF; bus1.req_din = 8'h5A;
    @(negedge clk);
    checkOutput("t4_write_not_blocked", 32'(bus1.req_ready), 32'd1);
    @(posedge clk); #1;
    bus1.req_we = 1'b0; bus1.req_addr = 11'd3;
    @(negedge clk);
    checkOutput("t4_ready_low_c", 32'(bus1.req_ready), 32'd0);
    @(posedge clk); #1;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_ready_on_pop", 32'(bus1.req_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 11'h020, 8'h00, 8'h00);
    waitDrain(1'b1);

    // Test 5: read in the cycle right after a write to the same address.
    applyStimulus(1'b1, 1'b1, 11'd7, 8'hFF, 8'h3C);
    applyStimulus(1'b1, 1'b0, 11'd7, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t5_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
    checkOutput("t5_rsp_dout", 32'(bus1.rsp_dout), 32'h3C);
    @(posedge clk); #1;
    waitDrain(1'b1);

    // Test 6: reset with responses pending on the non-clearing instance.
    rst0 = 1'b0;
    @(negedge clk);
    checkOutput("t6_ready_after_reset", 32'(bus0.req_ready), 32'd1);
    checkOutput("t6_init_done", 32'(initDone0), 32'd1);
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 11'd1, 8'hFF, 8'h11);
    applyStimulus(1'b0, 1'b1, 11'd2, 8'hFF, 8'h22);
    applyStimulus(1'b0, 1'b0, 11'd1, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 11'd2, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t6_rsp_pending", 32'(bus0.rsp_valid), 32'd1);
    @(posedge clk); #1;
    rst0 = 1'b1;
    @(negedge clk);
    checkOutput("t6_rstb_low", 32'(sramRstb0), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t6_rsp_valid_dropped", 32'(bus0.rsp_valid), 32'd0);
    checkOutput("t6_rsp_dout_reset", 32'(bus0.rsp_dout), 32'd0);
    checkOutput("t6_ready_in_reset", 32'(bus0.req_ready), 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_ready_first_cycle", 32'(bus0.req_ready), 32'd1);
    checkOutput("t6_rstb_high", 32'(sramRstb0), 32'd1);
    staleCnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus0.rsp_valid !== 1'b0) staleCnt++;
      @(negedge clk);
    end
    checkOutput("t6_no_stale", 32'(staleCnt), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 11'd2, 8'h00, 8'h00);
    waitDrain(1'b0);

    checkOutput("end_queues_empty", 32'(expQ1.size() + expQ0.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
